// File: rtl/ipv4_pkg.sv
// Shared Ethernet/IPv4 header constants, header field bundle and filter state encoding.
package ipv4_pkg;

   localparam int unsigned ETH_HDR_BYTES  = 14;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam int unsigned IPV4_MIN_HDR   = 20;
   localparam logic [7:0]  VER_IHL_IPV4   = 8'h45;
   localparam int unsigned IPV4_HDR_WORDS = IPV4_MIN_HDR / 2;

   // Byte offsets within beat 0 (byte n sits at tdata[8n+7:8n])
   localparam int unsigned OFF_ETHERTYPE = 12;
   localparam int unsigned OFF_VER_IHL   = 14;
   localparam int unsigned OFF_TOTAL_LEN = 16;
   localparam int unsigned OFF_CSUM      = 24;

   typedef struct packed {
      logic [15:0] ethertype;
      logic [7:0]  ver_ihl;
      logic [15:0] total_len;
   } ipv4_hdr_fields_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } filt_state_e;

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum verifier: ones'-complement sum of the ten
// 16-bit header words with end-around carry must equal 0xFFFF.
module ipv4_hdr_csum
   import ipv4_pkg::*;
(
   input  logic [8*IPV4_MIN_HDR-1:0] ip_hdr,
   output logic                      csum_ok
);

   localparam int unsigned SUM_W = 20;

   logic [SUM_W-1:0] sum;
   logic [16:0]      fold1;
   logic [15:0]      fold2;

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < IPV4_HDR_WORDS; i++) begin
         sum = sum + SUM_W'({ip_hdr[8*(2*i) +: 8], ip_hdr[8*(2*i+1) +: 8]});
      end
      // Two folds are enough: the first can carry out at most once more
      fold1   = 17'(sum[15:0]) + 17'(sum[SUM_W-1:16]);
      fold2   = fold1[15:0] + 16'(fold1[16]);
      csum_ok = (fold2 == 16'hFFFF);
   end

endmodule

// File: rtl/axis_ipv4_rx_filter.sv
// Cut-through AXI-Stream IPv4 filter: forwards well-formed IPv4 frames, drops the
// rest whole, and truncates oversize frames to the length implied by total_length.
module axis_ipv4_rx_filter
   import ipv4_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned MAX_IP_LEN = 2034,
   parameter int unsigned CHECK_CSUM = 1,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [CNT_WIDTH-1:0]  cnt_fwd,
   output logic [CNT_WIDTH-1:0]  cnt_drop,
   output logic [CNT_WIDTH-1:0]  cnt_len_err,
   output logic                  err_pulse
);

   localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
   localparam int unsigned BEAT_CNT_W = 8;
   localparam int unsigned LEN_SUM_W  = 17;

   filt_state_e            state_q, state_d;
   logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [BEAT_CNT_W-1:0]  exp_beats_q, exp_beats_d;
   logic                   run_q;

   ipv4_hdr_fields_t       hdr_c;
   logic                   csum_ok_c;
   logic                   len_ok_c;
   logic                   hdr_pass_c;
   logic [LEN_SUM_W-1:0]   frame_bytes_c;
   logic [BEAT_CNT_W-1:0]  exp_beats_c;
   logic                   discard_c;
   logic                   s_fire_c;
   logic                   fwd_c;
   logic                   force_last_c;
   logic                   drop_ev_c;
   logic                   len_ev_c;

   // Beat-0 header parse; only meaningful while in IDLE
   assign hdr_c.ethertype = {s_axis_tdata[8*OFF_ETHERTYPE +: 8], s_axis_tdata[8*(OFF_ETHERTYPE+1) +: 8]};
   assign hdr_c.ver_ihl   = s_axis_tdata[8*OFF_VER_IHL +: 8];
   assign hdr_c.total_len = {s_axis_tdata[8*OFF_TOTAL_LEN +: 8], s_axis_tdata[8*(OFF_TOTAL_LEN+1) +: 8]};

   ipv4_hdr_csum u_csum (
      .ip_hdr  (s_axis_tdata[8*OFF_VER_IHL +: 8*IPV4_MIN_HDR]),
      .csum_ok (csum_ok_c)
   );

   assign frame_bytes_c = LEN_SUM_W'(hdr_c.total_len) + LEN_SUM_W'(ETH_HDR_BYTES);
   assign exp_beats_c   = BEAT_CNT_W'((frame_bytes_c + LEN_SUM_W'(BEAT_BYTES - 1)) / LEN_SUM_W'(BEAT_BYTES));
   assign len_ok_c      = (hdr_c.total_len >= 16'(IPV4_MIN_HDR)) && (hdr_c.total_len <= 16'(MAX_IP_LEN));
   assign hdr_pass_c    = (hdr_c.ethertype == ETHERTYPE_IPV4) && (hdr_c.ver_ihl == VER_IHL_IPV4) &&
                          len_ok_c && ((CHECK_CSUM == 0) || csum_ok_c);

   // Discarded beats never touch the output register, so they need no slot there
   assign discard_c     = (state_q == DROP) || ((state_q == IDLE) && !hdr_pass_c);
   assign s_axis_tready = run_q && (discard_c || !m_axis_tvalid || m_axis_tready);
   assign s_fire_c      = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         exp_beats_q <= '0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         exp_beats_q <= exp_beats_d;
         run_q       <= 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      exp_beats_d  = exp_beats_q;
      fwd_c        = 1'b0;
      force_last_c = 1'b0;
      drop_ev_c    = 1'b0;
      len_ev_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_fire_c) begin
               if (hdr_pass_c) begin
                  fwd_c       = 1'b1;
                  exp_beats_d = exp_beats_c;
                  if (!s_axis_tlast) begin
                     if (exp_beats_c == BEAT_CNT_W'(1)) begin
                        force_last_c = 1'b1;
                        len_ev_c     = 1'b1;
                        state_d      = DROP;
                     end else begin
                        beat_cnt_d = BEAT_CNT_W'(1);
                        state_d    = FWD;
                     end
                  end
               end else begin
                  drop_ev_c = 1'b1;
                  if (!s_axis_tlast) state_d = DROP;
               end
            end
         end
         FWD: begin
            if (s_fire_c) begin
               fwd_c      = 1'b1;
               beat_cnt_d = BEAT_CNT_W'(beat_cnt_q + BEAT_CNT_W'(1));
               if (BEAT_CNT_W'(beat_cnt_q + BEAT_CNT_W'(1)) == exp_beats_q) begin
                  force_last_c = 1'b1;
                  if (s_axis_tlast) begin
                     state_d = IDLE;
                  end else begin
                     len_ev_c = 1'b1;
                     state_d  = DROP;
                  end
               end else if (s_axis_tlast) begin
                  len_ev_c = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         DROP: begin
            if (s_fire_c && s_axis_tlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register slice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (s_fire_c && fwd_c) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tlast  <= s_axis_tlast || force_last_c;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   // Statistics and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_fwd     <= '0;
         cnt_drop    <= '0;
         cnt_len_err <= '0;
         err_pulse   <= 1'b0;
      end else begin
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) cnt_fwd <= cnt_fwd + CNT_WIDTH'(1);
         if (drop_ev_c) cnt_drop    <= cnt_drop + CNT_WIDTH'(1);
         if (len_ev_c)  cnt_len_err <= cnt_len_err + CNT_WIDTH'(1);
         err_pulse <= drop_ev_c || len_ev_c;
      end
   end

endmodule

// File: tb/tb_axis_ipv4_rx_filter.sv
// Directed bench for axis_ipv4_rx_filter: pass/drop/truncate/short/backpressure/reset cases.
module tb_axis_ipv4_rx_filter;

   localparam int unsigned DW = 512;
   localparam int unsigned CW = 32;

   typedef logic [DW-1:0] beat_t;
   typedef logic [DW:0]   obeat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   beat_t         s_tdata;
   logic          s_tvalid;
   logic          s_axis_tready;
   logic          s_tlast;
   beat_t         m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_ready = 1'b1;
   logic          m_axis_tlast;
   logic [CW-1:0] cnt_fwd, cnt_drop, cnt_len_err;
   logic          err_pulse;

   int     n_checks = 0;
   int     n_errors = 0;
   bit     rand_rdy = 1'b0;
   bit     watch_rdy = 1'b0;
   int     rdy_low = 0;
   int     err_hi = 0;
   int     err_rise = 0;
   bit     err_prev = 1'b0;
   bit     stall_prev = 1'b0;
   obeat_t held;
   int     max_wait = 0;

   beat_t  frame_q[$];
   obeat_t exp_q[$];
   obeat_t out_q[$];

   axis_ipv4_rx_filter #(
      .DATA_WIDTH (DW),
      .MAX_IP_LEN (2034),
      .CHECK_CSUM (1),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_ready),
      .m_axis_tlast  (m_axis_tlast),
      .cnt_fwd       (cnt_fwd),
      .cnt_drop      (cnt_drop),
      .cnt_len_err   (cnt_len_err),
      .err_pulse     (err_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [575:0] act, input logic [575:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic beat_t fill(input logic [7:0] id, input logic [7:0] n);
      return {16{8'hA5, id, n, 8'h3C}};
   endfunction

   // Beat 0 with Ethernet + IPv4 header and a correct header checksum
   function automatic beat_t hdr(input logic [15:0] et, input logic [7:0] vi,
                                 input logic [15:0] len, input logic [7:0] id);
      beat_t       b;
      logic [19:0] s;
      logic [15:0] w;
      b = fill(id, 8'd0);
      b[8*12 +: 8] = et[15:8];  b[8*13 +: 8] = et[7:0];
      b[8*14 +: 8] = vi;        b[8*15 +: 8] = 8'h00;
      b[8*16 +: 8] = len[15:8]; b[8*17 +: 8] = len[7:0];
      b[8*18 +: 8] = 8'h12;     b[8*19 +: 8] = id;
      b[8*20 +: 8] = 8'h40;     b[8*21 +: 8] = 8'h00;
      b[8*22 +: 8] = 8'h40;     b[8*23 +: 8] = 8'h11;
      b[8*24 +: 8] = 8'h00;     b[8*25 +: 8] = 8'h00;
      b[8*26 +: 8] = 8'hC0;     b[8*27 +: 8] = 8'hA8;
      b[8*28 +: 8] = 8'h00;     b[8*29 +: 8] = 8'h01;
      b[8*30 +: 8] = 8'hC0;     b[8*31 +: 8] = 8'hA8;
      b[8*32 +: 8] = 8'h00;     b[8*33 +: 8] = 8'hC7;
      s = '0;
      for (int i = 0; i < 10; i++) s = s + 20'({b[8*(14+2*i) +: 8], b[8*(15+2*i) +: 8]});
      s = 20'(s[15:0]) + 20'(s[19:16]);
      s = 20'(s[15:0]) + 20'(s[19:16]);
      w = ~s[15:0];
      b[8*24 +: 8] = w[15:8];
      b[8*25 +: 8] = w[7:0];
      return b;
   endfunction

   // Sends frame_q; must be called at posedge+1, returns at posedge+1 after the last accept
   task automatic send_frame(input bit last_on_end);
      for (int i = 0; i < frame_q.size(); i++) begin
         int   n;
         logic rdy;
         n        = 0;
         s_tdata  = frame_q[i];
         s_tlast  = last_on_end && (i == frame_q.size() - 1);
         s_tvalid = 1'b1;
         do begin
            @(negedge clk);
            rdy = s_axis_tready;
            @(posedge clk);
            n++;
         end while (!rdy && n < 200);
         if (!rdy) chk("send_timeout", 0, 1);
         if (n > max_wait) max_wait = n;
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic expect_frame(input int nb);
      for (int i = 0; i < nb; i++) exp_q.push_back({(i == nb - 1) ? 1'b1 : 1'b0, frame_q[i]});
   endtask

   task automatic drain();
      rand_rdy = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic compare_out(input string tag);
      chk({tag, "_nbeats"}, 576'(out_q.size()), 576'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), 576'(out_q[i]), 576'(exp_q[i]));
      out_q.delete();
      exp_q.delete();
   endtask

   always @(posedge clk) begin
      #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: collects handshakes, checks hold-while-stalled, tracks err_pulse
   always @(negedge clk) begin
      if (m_axis_tvalid && m_ready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      if (stall_prev && m_axis_tvalid) chk("stall_hold", 576'({m_axis_tlast, m_axis_tdata}), 576'(held));
      stall_prev = m_axis_tvalid && !m_ready && rst_n;
      held       = {m_axis_tlast, m_axis_tdata};
      if (err_pulse) err_hi++;
      if (err_pulse && !err_prev) err_rise++;
      err_prev = err_pulse;
      if (watch_rdy && !s_axis_tready) rdy_low++;
   end

   initial begin
      beat_t b;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", 576'(m_axis_tvalid), 0);
      chk("rst_m_data", 576'(m_axis_tdata), 0);
      chk("rst_cnt_fwd", 576'(cnt_fwd), 0);
      chk("rst_s_ready", 576'(s_axis_tready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Valid 100-byte frame, 2 beats
      frame_q = '{hdr(16'h0800, 8'h45, 16'd100, 8'h01), fill(8'h01, 8'd1)};
      expect_frame(2);
      max_wait = 0;
      send_frame(1'b1);
      chk("t1_lat_valid", 576'(m_axis_tvalid), 1);
      chk("t1_lat_data", 576'(m_axis_tdata), 576'(frame_q[1]));
      chk("t1_lat_last", 576'(m_axis_tlast), 1);
      chk("t1_no_stall", 576'(max_wait), 1);
      drain();
      compare_out("t1");
      chk("t1_cnt_fwd", 576'(cnt_fwd), 1);

      // Three header failures: bad checksum, IPv6 ethertype, IHL=6
      err_hi = 0; err_rise = 0; rdy_low = 0; watch_rdy = 1'b1;
      b = hdr(16'h0800, 8'h45, 16'd100, 8'h02);
      b[8*24 +: 8] = ~b[8*24 +: 8];
      frame_q = '{b, fill(8'h02, 8'd1)};
      send_frame(1'b1);
      frame_q = '{hdr(16'h86DD, 8'h45, 16'd100, 8'h03), fill(8'h03, 8'd1)};
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h46, 16'd100, 8'h04), fill(8'h04, 8'd1)};
      send_frame(1'b1);
      drain();
      watch_rdy = 1'b0;
      compare_out("t2");
      chk("t2_cnt_drop", 576'(cnt_drop), 3);
      chk("t2_cnt_fwd", 576'(cnt_fwd), 1);
      chk("t2_err_rises", 576'(err_rise), 3);
      chk("t2_err_cycles", 576'(err_hi), 3);
      chk("t2_ready_low", 576'(rdy_low), 0);

      // Oversize: total_length 100 but 4 beats -> truncated to 2
      frame_q = '{hdr(16'h0800, 8'h45, 16'd100, 8'h05), fill(8'h05, 8'd1),
                  fill(8'h05, 8'd2), fill(8'h05, 8'd3)};
      expect_frame(2);
      send_frame(1'b1);
      drain();
      compare_out("t3");
      chk("t3_cnt_len_err", 576'(cnt_len_err), 1);
      chk("t3_cnt_fwd", 576'(cnt_fwd), 2);
      chk("t3_cnt_drop", 576'(cnt_drop), 3);

      // Short: total_length 300 (5 beats expected) ends after 3, then a normal frame
      frame_q = '{hdr(16'h0800, 8'h45, 16'd300, 8'h06), fill(8'h06, 8'd1), fill(8'h06, 8'd2)};
      expect_frame(3);
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h45, 16'd100, 8'h07), fill(8'h07, 8'd1)};
      expect_frame(2);
      send_frame(1'b1);
      drain();
      compare_out("t4");
      chk("t4_cnt_len_err", 576'(cnt_len_err), 2);
      chk("t4_cnt_fwd", 576'(cnt_fwd), 4);

      // Back-to-back frames of 2, 4, 1 and 3 beats under random backpressure
      rand_rdy = 1'b1;
      frame_q = '{hdr(16'h0800, 8'h45, 16'd100, 8'h10), fill(8'h10, 8'd1)};
      expect_frame(2);
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h45, 16'd200, 8'h11), fill(8'h11, 8'd1),
                  fill(8'h11, 8'd2), fill(8'h11, 8'd3)};
      expect_frame(4);
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h45, 16'd50, 8'h12)};
      expect_frame(1);
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h45, 16'd130, 8'h13), fill(8'h13, 8'd1), fill(8'h13, 8'd2)};
      expect_frame(3);
      send_frame(1'b1);
      drain();
      compare_out("t5");
      chk("t5_cnt_fwd", 576'(cnt_fwd), 8);
      chk("t5_cnt_len_err", 576'(cnt_len_err), 2);

      // Reset in the middle of a 3-beat frame; the orphaned tail is dropped
      frame_q = '{hdr(16'h0800, 8'h45, 16'd130, 8'h20), fill(8'h20, 8'd1)};
      send_frame(1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_m_valid", 576'(m_axis_tvalid), 0);
      chk("mid_rst_m_data", 576'(m_axis_tdata), 0);
      chk("mid_rst_m_last", 576'(m_axis_tlast), 0);
      chk("mid_rst_cnt_fwd", 576'(cnt_fwd), 0);
      chk("mid_rst_cnt_drop", 576'(cnt_drop), 0);
      chk("mid_rst_cnt_len", 576'(cnt_len_err), 0);
      chk("mid_rst_err", 576'(err_pulse), 0);
      chk("mid_rst_s_ready", 576'(s_axis_tready), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      out_q.delete();
      frame_q = '{fill(8'h20, 8'd2)};
      send_frame(1'b1);
      frame_q = '{hdr(16'h0800, 8'h45, 16'd100, 8'h30), fill(8'h30, 8'd1)};
      expect_frame(2);
      send_frame(1'b1);
      drain();
      compare_out("t6");
      chk("t6_cnt_drop", 576'(cnt_drop), 1);
      chk("t6_cnt_fwd", 576'(cnt_fwd), 1);
      chk("t6_cnt_len_err", 576'(cnt_len_err), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_ipv4_rx_filter.md
Name: axis_ipv4_rx_filter

Overview:
Cut-through AXI-Stream filter placed directly upstream of the IPv4-to-AXI4 DMA writer. It parses beat 0 of each Ethernet/IPv4 frame and forwards only well-formed IPv4 packets; all other frames are discarded whole. It also truncates oversize frames so the downstream writer always receives at most ceil((total_length+14)/BEAT_BYTES) beats. A 1-beat register stage provides registered outputs with full backpressure.

Parameters:
DATA_WIDTH, 512, stream width in bits; must be >= 512 so beat 0 holds the 14-byte Ethernet header plus the 20-byte IPv4 header.
MAX_IP_LEN, 2034, largest accepted IPv4 total_length in bytes (2048-byte downstream buffer minus 14).
CHECK_CSUM, 1, 1 = verify IPv4 header checksum; 0 = skip the check.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axis_tdata  in  DATA_WIDTH  input frame data; byte n at bits [8n+7:8n]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of the input frame
m_axis_tdata  out  DATA_WIDTH  output data to the writer
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of the output frame
cnt_fwd  out  CNT_WIDTH  count of frames forwarded
cnt_drop  out  CNT_WIDTH  count of frames dropped by header checks
cnt_len_err  out  CNT_WIDTH  count of frames that were short or truncated
err_pulse  out  1  one-cycle pulse on any drop or length error

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0. An asynchronous reset mid-frame abandons the frame. After reset the block waits in IDLE, and the next accepted beat is treated as beat 0. The tail of an interrupted upstream frame is therefore parsed as a new header and is usually dropped.
- Header fields, all big-endian. MSB byte is the lower byte index:
  - ethertype = bytes 12,13
  - ver/IHL = byte 14
  - total_length = bytes 16,17, i.e. {tdata[135:128], tdata[143:136]}
  - header checksum covers bytes 14..33
- A frame passes only if all of the following hold. Otherwise it is dropped.
  - ethertype == 0x0800
  - version == 4 and IHL == 5 (IPv4 options are dropped)
  - 20 <= total_length <= MAX_IP_LEN
  - when CHECK_CSUM = 1: the ones'-complement 16-bit sum of the 10 header words, with end-around carry, equals 0xFFFF
- Decision logic is combinational on beat 0 and is taken in the cycle beat 0 is accepted.
- exp_beats = ceil((total_length + 14) / (DATA_WIDTH/8)). Use a 17-bit sum for total_length + 14; the beat counter is 8 bits.
- States:
  - IDLE: waiting for beat 0. On accept:
    - pass and tlast -> forward; stay IDLE.
    - pass, not tlast, exp_beats == 1 -> forward with forced tlast; go to DROP; count len_err.
    - pass otherwise -> forward; beat counter = 1; go to FWD.
    - fail -> not forwarded; cnt_drop++; go to DROP unless tlast.
  - FWD: forward each accepted beat and increment the beat counter.
    - On the beat where count+1 == exp_beats: force m_axis_tlast = 1. If s_axis_tlast = 0, go to DROP and cnt_len_err++ (truncation); otherwise go to IDLE.
    - On s_axis_tlast before exp_beats is reached: forward the beat with tlast; cnt_len_err++ (short frame); go to IDLE.
  - DROP: s_axis_tready = 1; discard beats until s_axis_tlast is accepted, then go to IDLE.
- cnt_fwd increments when the output beat carrying m_axis_tlast completes its handshake. Truncated and short frames count in both cnt_fwd and cnt_len_err.
- Output register stage:
  - s_axis_tready = (state == DROP) || (beat would be discarded in IDLE) || !m_axis_tvalid || m_axis_tready.
  - m_axis_tvalid/tdata/tlast load only on an accepted, forwarded beat. m_axis_tvalid clears on m_axis_tready when no new beat is loaded.
  - Latency is 1 cycle; full throughput is 1 beat/cycle under continuous ready.
- Output stability: m_axis_tdata and m_axis_tlast hold steady while m_axis_tvalid = 1 and m_axis_tready = 0.
- Counters wrap at 2^CNT_WIDTH.
- Simultaneous events: when a drop and a len_err occur in the same cycle, both counters increment. err_pulse is the OR of the two events.

Decomposition:
- Shared package ipv4_pkg holds:
  - ETH_HDR_BYTES = 14, ETHERTYPE_IPV4 = 16'h0800, IPV4_MIN_HDR = 20
  - byte-offset constants for ethertype, ver/IHL, total_length and checksum
  - the filter state enum {IDLE, FWD, DROP}
  The downstream writer also reuses the package for its total_length offset.
- One sub-module, ipv4_hdr_csum: combinational 10-word ones'-complement adder tree with end-around carry. It outputs csum_ok for bytes 14..33 of the beat.

Test Plan:
- Valid 100-byte IPv4 frame, 2 beats (total_length 0x0064, correct checksum), m_axis_tready = 1 -> 2 output beats identical to input, tlast on beat 2, cnt_fwd = 1, 1-cycle latency, no stalls.
- Same frame with checksum byte 24 flipped; then ethertype 0x86DD; then IHL = 6 -> none forwarded, cnt_drop = 3, err_pulse three single-cycle pulses, s_axis_tready held at 1 throughout.
- total_length 100 but 4 input beats -> 2 beats out, tlast forced on beat 2, beats 3-4 absorbed, cnt_len_err = 1, cnt_fwd = 1.
- total_length 300 (5 expected beats) with tlast on beat 3 -> 3 beats out with tlast on beat 3, cnt_len_err = 1, next frame parsed correctly.
- Back-to-back valid frames with random m_axis_tready (50%) -> data and tlast match a reference model; no beat lost or duplicated; outputs stable while stalled.
- rst_n asserted on beat 2 of a 3-beat frame, then released; a valid frame follows -> all outputs 0 during reset; the orphaned beat 3 is dropped (cnt_drop = 1); the following valid frame is forwarded.
